// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM geometry and L2 address field widths
package dram_pkg;
  localparam int NUM_OF_BANKS = 8;
  localparam int NUM_OF_ROWS  = 128;
  localparam int NUM_OF_COLS  = 8;
  localparam int BW           = $clog2(NUM_OF_BANKS);
  localparam int RW           = $clog2(NUM_OF_ROWS);
  localparam int CW           = $clog2(NUM_OF_COLS);
  localparam int ADDR_WIDTH   = 13;
  localparam int DATA_WIDTH   = 32;
  localparam int FIFO_DEPTH   = 4;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/dram_resp_fifo.sv
// rtl/dram_resp_fifo.sv - response buffer: storage, pointers, occupancy count
module dram_resp_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Caller guarantees push only when not full and pop only when not empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/dram_l2_resp_formatter.sv
// rtl/dram_l2_resp_formatter.sv - rebuilds L2 address from bank/row/col and buffers responses to L2
module dram_l2_resp_formatter
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH   = dram_pkg::ADDR_WIDTH,
  parameter int NUM_OF_BANKS = dram_pkg::NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = dram_pkg::NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = dram_pkg::NUM_OF_COLS,
  parameter int DATA_WIDTH   = dram_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH   = dram_pkg::FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dram_rd_valid,
  output logic                            dram_rd_ready,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] dram_rd_bank_id,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  dram_rd_row_id,
  input  logic [$clog2(NUM_OF_COLS)-1:0]  dram_rd_col_id,
  input  logic [DATA_WIDTH-1:0]           dram_rd_data,
  output logic                            l2_resp_valid,
  input  logic                            l2_resp_ready,
  output logic [ADDR_WIDTH-1:0]           l2_resp_address,
  output logic [DATA_WIDTH-1:0]           l2_resp_data,
  output logic [$clog2(FIFO_DEPTH):0]     resp_count,
  output logic                            resp_drop_err
);
  localparam int BWL = $clog2(NUM_OF_BANKS);
  localparam int RWL = $clog2(NUM_OF_ROWS);
  localparam int CWL = $clog2(NUM_OF_COLS);

  if (ADDR_WIDTH != BWL + RWL + CWL) begin : g_bad_addr_width
    $error("dram_l2_resp_formatter: ADDR_WIDTH must equal bank+row+col bits");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("dram_l2_resp_formatter: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [ADDR_WIDTH-1:0]            in_addr;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
  logic                             push, pop, full, empty;
  logic                             drop_err_q, drop_err_d;

  assign in_addr = {dram_rd_bank_id, dram_rd_row_id, dram_rd_col_id};

  // Ready depends only on registered occupancy; a same-cycle pop never frees a slot.
  assign dram_rd_ready = !full;
  assign l2_resp_valid = !empty;
  assign push          = dram_rd_valid & dram_rd_ready;
  assign pop           = l2_resp_valid & l2_resp_ready;

  dram_resp_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_addr, dram_rd_data}),
    .pop   (pop),
    .rdata (head),
    .count (resp_count),
    .full  (full),
    .empty (empty)
  );

  assign l2_resp_address = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign l2_resp_data    = head[DATA_WIDTH-1:0];

  always_comb begin
    drop_err_d = drop_err_q | (dram_rd_valid & ~dram_rd_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_err_q <= 1'b0;
    else        drop_err_q <= drop_err_d;
  end

  assign resp_drop_err = drop_err_q;
endmodule

// File: tb/tb_dram_l2_resp_formatter.sv
// tb/tb_dram_l2_resp_formatter.sv - self-checking bench for dram_l2_resp_formatter
module tb_dram_l2_resp_formatter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dram_rd_valid;
  logic        dram_rd_ready;
  logic [2:0]  dram_rd_bank_id;
  logic [6:0]  dram_rd_row_id;
  logic [2:0]  dram_rd_col_id;
  logic [31:0] dram_rd_data;
  logic        l2_resp_valid;
  logic        l2_resp_ready;
  logic [12:0] l2_resp_address;
  logic [31:0] l2_resp_data;
  logic [2:0]  resp_count;
  logic        resp_drop_err;

  always #5 clk = ~clk;

  dram_l2_resp_formatter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dram_rd_valid   (dram_rd_valid),
    .dram_rd_ready   (dram_rd_ready),
    .dram_rd_bank_id (dram_rd_bank_id),
    .dram_rd_row_id  (dram_rd_row_id),
    .dram_rd_col_id  (dram_rd_col_id),
    .dram_rd_data    (dram_rd_data),
    .l2_resp_valid   (l2_resp_valid),
    .l2_resp_ready   (l2_resp_ready),
    .l2_resp_address (l2_resp_address),
    .l2_resp_data    (l2_resp_data),
    .resp_count      (resp_count),
    .resp_drop_err   (resp_drop_err)
  );

  typedef struct {
    logic [2:0]  bank;
    logic [6:0]  row;
    logic [2:0]  col;
    logic [31:0] data;
    logic [12:0] exp_addr;
  } vec_t;

  vec_t        vecs [6];
  logic [44:0] sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left just after a falling edge; drives one cycle of stimulus,
  // updates the scoreboard from the handshake that the next rising edge commits.
  task automatic step(input logic v, input vec_t x, input logic rr);
    logic [44:0] e;
    dram_rd_valid   = v;
    dram_rd_bank_id = x.bank;
    dram_rd_row_id  = x.row;
    dram_rd_col_id  = x.col;
    dram_rd_data    = x.data;
    l2_resp_ready   = rr;
    #1;
    if (v && dram_rd_ready) sb.push_back({x.exp_addr, x.data});
    if (v && !dram_rd_ready) exp_err = 1'b1;
    if (l2_resp_valid && rr) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'(l2_resp_address), 64'h0);
        n_bad += (l2_resp_address === 13'h0) ? 1 : 0;
      end else begin
        e = sb.pop_front();
        chk("resp_addr", 64'(l2_resp_address), 64'(e[44:32]));
        chk("resp_data", 64'(l2_resp_data), 64'(e[31:0]));
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drop_err", 64'(resp_drop_err), 64'(exp_err));
  endtask

  task automatic idle(input logic rr);
    vec_t z;
    z = '{3'd0, 7'd0, 3'd0, 32'd0, 13'd0};
    step(1'b0, z, rr);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{3'd3, 7'd5,   3'd2, 32'hA5A5A5A5, 13'h0C2A};
    vecs[1] = '{3'd7, 7'd127, 3'd7, 32'hDEADBEEF, 13'h1FFF};
    vecs[2] = '{3'd0, 7'd0,   3'd0, 32'h12345678, 13'h0000};
    vecs[3] = '{3'd1, 7'd64,  3'd4, 32'h0F0F0F0F, 13'h0604};
    vecs[4] = '{3'd5, 7'd85,  3'd1, 32'hCAFEF00D, 13'h16A9};
    vecs[5] = '{3'd2, 7'd1,   3'd6, 32'h00000001, 13'h080E};

    rst_n = 1'b0;
    dram_rd_valid = 1'b0; dram_rd_bank_id = '0; dram_rd_row_id = '0;
    dram_rd_col_id = '0; dram_rd_data = '0; l2_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Test 1: reset state
    chk("rst_valid", 64'(l2_resp_valid), 64'd0);
    chk("rst_ready", 64'(dram_rd_ready), 64'd1);
    chk("rst_count", 64'(resp_count), 64'd0);
    chk("rst_addr",  64'(l2_resp_address), 64'd0);
    chk("rst_data",  64'(l2_resp_data), 64'd0);
    chk("rst_err",   64'(resp_drop_err), 64'd0);
    idle(1'b1);

    // Test 2: each vector alone -> valid next cycle, popped, then empty
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vecs[i], 1'b1);
      chk("single_valid", 64'(l2_resp_valid), 64'd1);
      chk("single_addr",  64'(l2_resp_address), 64'(vecs[i].exp_addr));
      idle(1'b1);
      chk("single_empty", 64'(l2_resp_valid), 64'd0);
    end

    // Test 3: back-to-back extremes, order preserved
    step(1'b1, vecs[1], 1'b0);
    step(1'b1, vecs[2], 1'b0);
    chk("b2b_count", 64'(resp_count), 64'd2);
    idle(1'b1);
    idle(1'b1);

    // Test 4: fill, overflow drop, head stable, drain
    for (int i = 0; i < 4; i++) step(1'b1, vecs[i], 1'b0);
    chk("full_count", 64'(resp_count), 64'd4);
    chk("full_ready", 64'(dram_rd_ready), 64'd0);
    chk("full_head",  64'(l2_resp_address), 64'(vecs[0].exp_addr));
    step(1'b1, vecs[4], 1'b0);
    chk("drop_err_set", 64'(resp_drop_err), 64'd1);
    chk("drop_count",   64'(resp_count), 64'd4);
    chk("drop_head",    64'(l2_resp_data), 64'(vecs[0].data));
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_count", 64'(resp_count), 64'd0);
    chk("drain_err",   64'(resp_drop_err), 64'd1);

    // Test 5: push and pop together at count==1, ten times
    step(1'b1, vecs[5], 1'b0);
    for (int i = 0; i < 10; i++) begin
      v = '{3'(i), 7'(i * 13), 3'(7 - (i % 8)), 32'(32'h1000 + i), 13'h0};
      v.exp_addr = 13'((i % 8) * 1024 + ((i * 13) % 128) * 8 + (7 - (i % 8)));
      step(1'b1, v, 1'b1);
      chk("pp_count", 64'(resp_count), 64'd1);
      chk("pp_valid", 64'(l2_resp_valid), 64'd1);
    end
    idle(1'b1);
    chk("pp_empty", 64'(resp_count), 64'd0);

    // Test 6: reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, vecs[i + 3], 1'b0);
    chk("pre_rst_count", 64'(resp_count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(resp_count), 64'd0);
    chk("mid_rst_valid", 64'(l2_resp_valid), 64'd0);
    chk("mid_rst_ready", 64'(dram_rd_ready), 64'd1);
    chk("mid_rst_err",   64'(resp_drop_err), 64'd0);
    chk("mid_rst_addr",  64'(l2_resp_address), 64'd0);
    chk("mid_rst_data",  64'(l2_resp_data), 64'd0);
    sb.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(1'b1, vecs[0], 1'b0);
    chk("post_rst_valid", 64'(l2_resp_valid), 64'd1);
    idle(1'b1);
    chk("post_rst_empty", 64'(resp_count), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
